// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcode match constants for the LEGv8 immediate generator
package imm_gen_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_I    = 3'd3,
    FMT_B    = 3'd4
  } fmt_e;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [6:0]  OP_CB   = 7'b1011010;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // imm is held at full width so the struct is usable for any DW
  typedef struct packed {
    logic [MAX_W-1:0] imm;
    fmt_e             fmt;
    logic             illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational LEGv8 immediate decode; B format enabled by IMM_GEN_PIPE_BTYPE_EN
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [31:0]   instr,
  output logic [DW-1:0] imm,
  output fmt_e          fmt,
  output logic          illegal
);

  logic [MAX_W-1:0] imm_w;

  always_comb begin
    imm_w   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt   = FMT_D;
      imm_w = MAX_W'($signed(instr[20:12]));
    end else if (instr[31:25] == OP_CB) begin
      fmt   = FMT_CB;
      imm_w = MAX_W'($signed(instr[23:5]));
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      fmt   = FMT_I;
      imm_w = MAX_W'(instr[21:10]);
    end
`ifdef IMM_GEN_PIPE_BTYPE_EN
    else if (instr[31:26] == OP_B) begin
      fmt   = FMT_B;
      imm_w = MAX_W'($signed(instr[25:0]));
    end
`endif
    else begin
      illegal = 1'b1;
    end
  end

  assign imm = imm_w[DW-1:0];

`ifndef IMM_GEN_PIPE_BTYPE_EN
  logic unused_bits;
  assign unused_bits = ^{instr[24], instr[4:0]};
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - decoded-immediate FIFO with valid/ready handshake and saturating illegal counter
// Optional B-format decode is enabled by IMM_GEN_PIPE_BTYPE_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] dec_imm;
  fmt_e          dec_fmt;
  logic          dec_illegal;
  entry_t        dec_entry;

  imm_decode #(.DW(DW)) u_decode (
    .instr   (instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{imm: MAX_W'(dec_imm), fmt: dec_fmt, illegal: dec_illegal};

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             ready_q, ready_d;
  logic             push, pop;
  entry_t           head;

  // ready_q holds in_ready low until the first edge after reset release
  assign in_ready  = ready_q && (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    ready_d       = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // a word accepted on a flush edge is dropped but still counted
    if (push && dec_illegal && illegal_cnt_q != '1) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
      ready_q       <= ready_d;
    end
  end

  assign imm         = out_valid ? head.imm[DW-1:0] : '0;
  assign fmt         = out_valid ? head.fmt : FMT_NONE;
  assign illegal     = out_valid ? head.illegal : 1'b0;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed table-driven bench for imm_gen_pipe (DW=64, DEPTH=2, CNT_W=8)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic [7:0]  illegal_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        illegal;
  } vec_t;

  vec_t vecs [10];

  imm_gen_pipe #(.DW(64), .DEPTH(2), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .imm         (imm),
    .fmt         (fmt),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"ldur",      32'hF84103E0, 3'd1, 64'h10,               1'b0};
    vecs[1] = '{"stur_m1",   32'hF81FF000, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[2] = '{"stur_m256", 32'hF8100000, 3'd1, 64'hFFFFFFFFFFFFFF00, 1'b0};
    vecs[3] = '{"cbz_m1",    32'hB4FFFFE0, 3'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[4] = '{"cbnz_pos",  32'hB5000800, 3'd2, 64'h40,               1'b0};
    vecs[5] = '{"addi_fff",  32'h913FFC00, 3'd3, 64'hFFF,              1'b0};
    vecs[6] = '{"subi_800",  32'hD1200000, 3'd3, 64'h800,              1'b0};
    vecs[7] = '{"zero_word", 32'h00000000, 3'd0, 64'h0,                1'b1};
    vecs[8] = '{"near_d",    32'hF8600000, 3'd0, 64'h0,                1'b1};
`ifdef IMM_GEN_PIPE_BTYPE_EN
    vecs[9] = '{"b_m1",      32'h17FFFFFF, 3'd4, 64'hFFFFFFFFFFFFFFFF, 1'b0};
`else
    vecs[9] = '{"b_off",     32'h17FFFFFF, 3'd0, 64'h0,                1'b1};
`endif

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("pre_edge_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("post_edge_in_ready", 64'(in_ready), 64'd1);

    // single-word decode: accept, check head one cycle later, then pop
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1; instr = vecs[i].instr; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (vecs[i].illegal) exp_cnt++;
      check({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, "_fmt"}, 64'(fmt), 64'(vecs[i].fmt));
      check({vecs[i].name, "_imm"}, imm, vecs[i].imm);
      check({vecs[i].name, "_illegal"}, 64'(illegal), 64'(vecs[i].illegal));
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({vecs[i].name, "_popped"}, 64'(out_valid), 64'd0);
    end
    check("table_cnt", 64'(illegal_cnt), 64'(exp_cnt));

    // backpressure: third word held until a pop, order preserved
    @(negedge clk);
    in_valid = 1'b1; instr = 32'hF84103E0; out_ready = 1'b0;
    @(negedge clk);
    instr = 32'h913FFC00;
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head_a", imm, 64'h10);
    instr = 32'hB4FFFFE0;
    @(negedge clk);
    check("bp_held_ready", 64'(in_ready), 64'd0);
    check("bp_held_head", imm, 64'h10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_head_b_fmt", 64'(fmt), 64'd3);
    check("bp_head_b_imm", imm, 64'hFFF);
    check("bp_ready_again", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_full_again", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_c_fmt", 64'(fmt), 64'd2);
    check("bp_head_c_imm", imm, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);

    // 300 illegal words streamed with out_ready high: counter saturates
    in_valid = 1'b1; instr = 32'h0000_0000;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (n == 99) check("sat_mid_cnt", 64'(illegal_cnt), 64'(exp_cnt));
    end
    check("sat_cnt", 64'(illegal_cnt), 64'd255);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_flush_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_cnt", 64'(illegal_cnt), 64'd255);
    check("flush_fmt", 64'(fmt), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);

    // async reset with two entries held
    in_valid = 1'b1; instr = 32'hF84103E0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold2_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd0);
    check("async_rst_imm", imm, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'd1);
    check("rel_valid", 64'(out_valid), 64'd0);
    check("rel_cnt", 64'(illegal_cnt), 64'd0);

    // illegal word accepted on a flush edge is discarded but counted
    in_valid = 1'b1; instr = 32'h0000_0000; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_edge_valid", 64'(out_valid), 64'd0);
    check("flush_edge_cnt", 64'(illegal_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
